// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream video test-pattern source with programmable blanking and a frame counter.
// Optional macro AXIS_PATTERN_THROTTLE_EN adds LFSR-driven tvalid throttling between beats.
module axis_video_pattern_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 1,
  parameter int IMG_WIDTH  = 800,
  parameter int IMG_HEIGHT = 400,
  parameter int H_BLANK    = 16,
  parameter int V_BLANK    = 64,
  parameter int CH_OFFSET  = 64
) (
  input  logic                           i_clk,
  input  logic                           i_areset,
  input  logic                           i_enable,
  input  logic [1:0]                     i_mode,
  input  logic [DATA_WIDTH-1:0]          i_const,
  output logic [DATA_WIDTH*CHANNELS-1:0] m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tuser,
  output logic                           m_axis_tlast,
  output logic                           o_busy,
  output logic [15:0]                    o_frame_cnt
);

  localparam int XW        = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW        = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int BLANK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int BW        = ($clog2(BLANK_MAX + 1) < 1) ? 1 : $clog2(BLANK_MAX + 1);
  localparam int TW        = DATA_WIDTH * CHANNELS;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_HBLANK = 2'd2;
  localparam logic [1:0] ST_VBLANK = 2'd3;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] X_ZERO = XW'(0);
  localparam logic [YW-1:0] Y_ZERO = YW'(0);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);
  localparam logic [BW-1:0] B_ONE  = BW'(1);

  // Base value per pattern, then replicated across channels with a per-channel offset.
  function automatic logic [TW-1:0] pixel_f(
    input logic [1:0]            mode,
    input logic [DATA_WIDTH-1:0] cval,
    input logic [XW-1:0]         x,
    input logic [YW-1:0]         y
  );
    logic [DATA_WIDTH-1:0] base;
    logic [TW-1:0]         px;
    case (mode)
      2'd0:    base = DATA_WIDTH'(x) + DATA_WIDTH'(y);
      2'd1:    base = DATA_WIDTH'(x);
      2'd2:    base = DATA_WIDTH'(y);
      2'd3:    base = cval;
      default: base = cval;
    endcase
    px = {TW{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      px[c*DATA_WIDTH +: DATA_WIDTH] = base + DATA_WIDTH'(c * CH_OFFSET);
    end
    return px;
  endfunction

  logic [1:0]            rst_sync_r;
  logic                  rst_hold_s;
  logic [1:0]            state_r, state_nxt_s;
  logic [XW-1:0]         x_r, x_nxt_s, lx_s;
  logic [YW-1:0]         y_r, y_nxt_s, ly_s;
  logic [BW-1:0]         cnt_r, cnt_nxt_s;
  logic [1:0]            mode_r, mode_nxt_s;
  logic [DATA_WIDTH-1:0] const_r, const_nxt_s;
  logic [TW-1:0]         tdata_r, tdata_nxt_s;
  logic                  tvalid_r, tvalid_nxt_s;
  logic                  tuser_r, tuser_nxt_s;
  logic                  tlast_r, tlast_nxt_s;
  logic [15:0]           fcnt_r, fcnt_nxt_s;
  logic                  busy_r;
  logic                  req_load_s, req_frame_s, req_thr_s, fdec_s;
  logic                  throttle_gap_s;

  // Reset release is held off for two clocks so every flop leaves reset on the same edge.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      rst_sync_r <= 2'b11;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b0};
    end
  end

  assign rst_hold_s = rst_sync_r[1];

`ifdef AXIS_PATTERN_THROTTLE_EN
  logic [15:0] lfsr_r;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, advancing only while a line is being sent.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      lfsr_r <= 16'hACE1;
    end else if (rst_hold_s) begin
      lfsr_r <= 16'hACE1;
    end else if (state_r == ST_ACTIVE) begin
      lfsr_r <= {lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5], lfsr_r[15:1]};
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign throttle_gap_s = ~lfsr_r[0];
`else
  assign throttle_gap_s = 1'b0;
`endif

  // Next-state and next-beat computation; a stalled beat simply keeps all defaults.
  always_comb begin
    state_nxt_s  = state_r;
    x_nxt_s      = x_r;
    y_nxt_s      = y_r;
    cnt_nxt_s    = cnt_r;
    mode_nxt_s   = mode_r;
    const_nxt_s  = const_r;
    tdata_nxt_s  = tdata_r;
    tvalid_nxt_s = tvalid_r;
    tuser_nxt_s  = tuser_r;
    tlast_nxt_s  = tlast_r;
    fcnt_nxt_s   = fcnt_r;
    req_load_s   = 1'b0;
    req_frame_s  = 1'b0;
    req_thr_s    = 1'b0;
    fdec_s       = 1'b0;
    lx_s         = x_r;
    ly_s         = y_r;

    case (state_r)
      ST_IDLE: begin
        if (i_enable) begin
          req_load_s  = 1'b1;
          req_frame_s = 1'b1;
          req_thr_s   = 1'b1;
          lx_s        = X_ZERO;
          ly_s        = Y_ZERO;
        end else begin
          tvalid_nxt_s = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (!tvalid_r) begin
          // Throttle gap already taken: present the beat parked in x_r/y_r.
          req_load_s = 1'b1;
        end else if (m_axis_tready) begin
          if (x_r != X_LAST) begin
            req_load_s = 1'b1;
            req_thr_s  = 1'b1;
            lx_s       = x_r + X_ONE;
          end else if (y_r != Y_LAST) begin
            if (H_BLANK > 0) begin
              state_nxt_s  = ST_HBLANK;
              cnt_nxt_s    = BW'(H_BLANK);
              tvalid_nxt_s = 1'b0;
              tuser_nxt_s  = 1'b0;
              tlast_nxt_s  = 1'b0;
              x_nxt_s      = X_ZERO;
              y_nxt_s      = y_r + Y_ONE;
            end else begin
              req_load_s = 1'b1;
              req_thr_s  = 1'b1;
              lx_s       = X_ZERO;
              ly_s       = y_r + Y_ONE;
            end
          end else begin
            fcnt_nxt_s = fcnt_r + 16'd1;
            if (V_BLANK > 0) begin
              state_nxt_s  = ST_VBLANK;
              cnt_nxt_s    = BW'(V_BLANK);
              tvalid_nxt_s = 1'b0;
              tuser_nxt_s  = 1'b0;
              tlast_nxt_s  = 1'b0;
            end else begin
              fdec_s = 1'b1;
            end
          end
        end else begin
          tvalid_nxt_s = 1'b1;
        end
      end
      ST_HBLANK: begin
        if (cnt_r <= B_ONE) begin
          req_load_s = 1'b1;
          req_thr_s  = 1'b1;
          lx_s       = X_ZERO;
          ly_s       = y_r;
        end else begin
          cnt_nxt_s = cnt_r - B_ONE;
        end
      end
      ST_VBLANK: begin
        if (cnt_r <= B_ONE) begin
          fdec_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - B_ONE;
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        tvalid_nxt_s = 1'b0;
      end
    endcase

    if (fdec_s) begin
      if (i_enable) begin
        req_load_s  = 1'b1;
        req_frame_s = 1'b1;
        req_thr_s   = 1'b1;
        lx_s        = X_ZERO;
        ly_s        = Y_ZERO;
      end else begin
        state_nxt_s  = ST_IDLE;
        tvalid_nxt_s = 1'b0;
        tuser_nxt_s  = 1'b0;
        tlast_nxt_s  = 1'b0;
        x_nxt_s      = X_ZERO;
        y_nxt_s      = Y_ZERO;
      end
    end else begin
      cnt_nxt_s = cnt_nxt_s;
    end

    if (req_load_s) begin
      state_nxt_s = ST_ACTIVE;
      x_nxt_s     = lx_s;
      y_nxt_s     = ly_s;
      if (req_frame_s) begin
        mode_nxt_s  = i_mode;
        const_nxt_s = i_const;
      end else begin
        mode_nxt_s  = mode_r;
      end
      if (req_thr_s && throttle_gap_s) begin
        tvalid_nxt_s = 1'b0;
        tuser_nxt_s  = 1'b0;
        tlast_nxt_s  = 1'b0;
      end else begin
        tvalid_nxt_s = 1'b1;
        tdata_nxt_s  = pixel_f(mode_nxt_s, const_nxt_s, lx_s, ly_s);
        tuser_nxt_s  = (lx_s == X_ZERO) && (ly_s == Y_ZERO);
        tlast_nxt_s  = (lx_s == X_LAST);
      end
    end else begin
      x_nxt_s = x_nxt_s;
    end

    if (rst_hold_s) begin
      state_nxt_s  = ST_IDLE;
      x_nxt_s      = X_ZERO;
      y_nxt_s      = Y_ZERO;
      cnt_nxt_s    = {BW{1'b0}};
      mode_nxt_s   = 2'd0;
      const_nxt_s  = {DATA_WIDTH{1'b0}};
      tdata_nxt_s  = {TW{1'b0}};
      tvalid_nxt_s = 1'b0;
      tuser_nxt_s  = 1'b0;
      tlast_nxt_s  = 1'b0;
      fcnt_nxt_s   = 16'd0;
    end else begin
      fcnt_nxt_s = fcnt_nxt_s;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_r  <= ST_IDLE;
      x_r      <= X_ZERO;
      y_r      <= Y_ZERO;
      cnt_r    <= {BW{1'b0}};
      mode_r   <= 2'd0;
      const_r  <= {DATA_WIDTH{1'b0}};
      tdata_r  <= {TW{1'b0}};
      tvalid_r <= 1'b0;
      tuser_r  <= 1'b0;
      tlast_r  <= 1'b0;
      fcnt_r   <= 16'd0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      x_r      <= x_nxt_s;
      y_r      <= y_nxt_s;
      cnt_r    <= cnt_nxt_s;
      mode_r   <= mode_nxt_s;
      const_r  <= const_nxt_s;
      tdata_r  <= tdata_nxt_s;
      tvalid_r <= tvalid_nxt_s;
      tuser_r  <= tuser_nxt_s;
      tlast_r  <= tlast_nxt_s;
      fcnt_r   <= fcnt_nxt_s;
      busy_r   <= (state_nxt_s != ST_IDLE);
    end
  end

  assign m_axis_tdata  = tdata_r;
  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tuser  = tuser_r;
  assign m_axis_tlast  = tlast_r;
  assign o_busy        = busy_r;
  assign o_frame_cnt   = fcnt_r;

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Directed bench for axis_video_pattern_gen on a 4x3 frame, two channels, blanking 2/3.
module tb_axis_video_pattern_gen;

  logic        i_clk = 1'b0;
  logic        i_areset = 1'b1;
  logic        i_enable = 1'b0;
  logic [1:0]  i_mode = 2'd0;
  logic [7:0]  i_const = 8'd0;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        o_busy;
  logic [15:0] o_frame_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic        rdy;
    logic [1:0]  mode;
    logic [7:0]  cval;
    logic        v;
    logic [15:0] d;
    logic        u;
    logic        l;
    logic [15:0] fc;
    logic        busy;
  } vec_t;

  vec_t        tbl [40];
  logic [15:0] beat_exp [12];

  axis_video_pattern_gen #(
    .DATA_WIDTH(8), .CHANNELS(2), .IMG_WIDTH(4), .IMG_HEIGHT(3),
    .H_BLANK(2), .V_BLANK(3), .CH_OFFSET(64)
  ) dut (
    .i_clk(i_clk), .i_areset(i_areset), .i_enable(i_enable), .i_mode(i_mode),
    .i_const(i_const), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .o_busy(o_busy), .o_frame_cnt(o_frame_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " tvalid"}, {31'd0, m_axis_tvalid}, 32'd0);
    check({tag, " tuser"}, {31'd0, m_axis_tuser}, 32'd0);
    check({tag, " tlast"}, {31'd0, m_axis_tlast}, 32'd0);
    check({tag, " tdata"}, {16'd0, m_axis_tdata}, 32'd0);
    check({tag, " busy"}, {31'd0, o_busy}, 32'd0);
    check({tag, " frame_cnt"}, {16'd0, o_frame_cnt}, 32'd0);
  endtask

  task automatic do_reset();
    i_enable = 1'b0;
    m_axis_tready = 1'b0;
    @(negedge i_clk);
    i_areset = 1'b1;
    #2;
    check_zero("reset");
    @(negedge i_clk);
    i_areset = 1'b0;
    repeat (4) @(negedge i_clk);
  endtask

  // One frame plus the first beat of the next, cycle by cycle, with tready held high.
  task automatic fill_frame(input int base, input logic [1:0] mode, input logic [7:0] cval,
                            input logic use_const);
    int k = base;
    int n = 0;
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 4; x++) begin
        tbl[k] = '{1'b1, 1'b1, mode, cval, 1'b1, use_const ? 16'h30F0 : beat_exp[n],
                   (n == 0), (x == 3), 16'd0, 1'b1};
        k++;
        n++;
      end
      for (int g = 0; g < ((y < 2) ? 2 : 3); g++) begin
        tbl[k] = '{1'b1, 1'b1, mode, cval, 1'b0, 16'h0000, 1'b0, 1'b0,
                   (y == 2) ? 16'd1 : 16'd0, 1'b1};
        k++;
      end
    end
    tbl[k] = '{1'b1, 1'b1, mode, cval, 1'b1, use_const ? 16'h30F0 : beat_exp[0],
               1'b1, 1'b0, 16'd1, 1'b1};
  endtask

  task automatic run_table(input int base);
    for (int k = base; k < base + 20; k++) begin
      i_enable = tbl[k].en;
      m_axis_tready = tbl[k].rdy;
      i_mode = tbl[k].mode;
      i_const = tbl[k].cval;
      @(posedge i_clk);
      @(negedge i_clk);
      check($sformatf("vec%0d tvalid", k), {31'd0, m_axis_tvalid}, {31'd0, tbl[k].v});
      if (tbl[k].v) begin
        check($sformatf("vec%0d tdata", k), {16'd0, m_axis_tdata}, {16'd0, tbl[k].d});
        check($sformatf("vec%0d tuser", k), {31'd0, m_axis_tuser}, {31'd0, tbl[k].u});
        check($sformatf("vec%0d tlast", k), {31'd0, m_axis_tlast}, {31'd0, tbl[k].l});
      end
      check($sformatf("vec%0d frame_cnt", k), {16'd0, o_frame_cnt}, {16'd0, tbl[k].fc});
      check($sformatf("vec%0d busy", k), {31'd0, o_busy}, {31'd0, tbl[k].busy});
    end
  endtask

  task automatic check_beat(input string tag, input int n);
    check($sformatf("%s beat%0d tdata", tag, n), {16'd0, m_axis_tdata}, {16'd0, beat_exp[n % 12]});
    check($sformatf("%s beat%0d tuser", tag, n), {31'd0, m_axis_tuser}, {31'd0, (n % 12) == 0});
    check($sformatf("%s beat%0d tlast", tag, n), {31'd0, m_axis_tlast}, {31'd0, (n % 4) == 3});
  endtask

  initial begin
    int ntx;
    int busy_after;
    int gaps;
    logic pv, pr, pu, pl;
    logic [15:0] pd;

    beat_exp = '{16'h4000, 16'h4101, 16'h4202, 16'h4303,
                 16'h4101, 16'h4202, 16'h4303, 16'h4404,
                 16'h4202, 16'h4303, 16'h4404, 16'h4505};
    fill_frame(0, 2'd0, 8'h00, 1'b0);
    fill_frame(20, 2'd3, 8'hF0, 1'b1);

    repeat (2) @(negedge i_clk);
    i_areset = 1'b0;
    repeat (4) @(negedge i_clk);
    check_zero("initial");

`ifndef AXIS_PATTERN_THROTTLE_EN
    // Mode 0 and mode 3 frames, exact cycle timing.
    do_reset();
    run_table(0);
    do_reset();
    run_table(20);

    // Back-pressure pattern 1,0,0,1: stalled beats must hold, order must match.
    do_reset();
    i_mode = 2'd0;
    i_enable = 1'b1;
    ntx = 0;
    pv = 1'b0; pr = 1'b1; pu = 1'b0; pl = 1'b0; pd = 16'h0;
    for (int c = 0; c < 300 && ntx < 12; c++) begin
      m_axis_tready = ((c % 4) == 0) || ((c % 4) == 3);
      if (pv && !pr) begin
        check("stall tvalid", {31'd0, m_axis_tvalid}, 32'd1);
        check("stall tdata", {16'd0, m_axis_tdata}, {16'd0, pd});
        check("stall tuser", {31'd0, m_axis_tuser}, {31'd0, pu});
        check("stall tlast", {31'd0, m_axis_tlast}, {31'd0, pl});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check_beat("stall", ntx);
        ntx++;
      end
      pv = m_axis_tvalid; pr = m_axis_tready; pd = m_axis_tdata;
      pu = m_axis_tuser; pl = m_axis_tlast;
      @(posedge i_clk);
      @(negedge i_clk);
    end
    check("stall transfers", ntx, 32'd12);

    // Enable dropped mid-frame: frame and its vertical blank still complete.
    do_reset();
    i_mode = 2'd0;
    i_enable = 1'b1;
    m_axis_tready = 1'b1;
    ntx = 0;
    busy_after = 0;
    for (int c = 0; c < 60; c++) begin
      if (ntx == 12 && o_busy) busy_after++;
      if (m_axis_tvalid) begin
        if (ntx < 12) check_beat("drop", ntx);
        ntx++;
      end
      if (ntx >= 5) i_enable = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
    end
    check("drop transfers", ntx, 32'd12);
    check("drop vblank cycles", busy_after, 32'd3);
    check("drop busy", {31'd0, o_busy}, 32'd0);
    check("drop tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("drop frame_cnt", {16'd0, o_frame_cnt}, 32'd1);

    // Reset while the 7th beat is stalled, then restart from pixel (0,0).
    do_reset();
    i_mode = 2'd0;
    i_enable = 1'b1;
    m_axis_tready = 1'b1;
    ntx = 0;
    for (int c = 0; c < 100 && ntx < 6; c++) begin
      if (m_axis_tvalid && m_axis_tready) ntx++;
      @(posedge i_clk);
      @(negedge i_clk);
    end
    m_axis_tready = 1'b0;
    check("rst7 tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    check("rst7 tdata", {16'd0, m_axis_tdata}, 32'h4303);
    @(posedge i_clk);
    @(negedge i_clk);
    check("rst7 held tdata", {16'd0, m_axis_tdata}, 32'h4303);
    #2;
    i_areset = 1'b1;
    #1;
    check_zero("midreset");
    @(negedge i_clk);
    i_areset = 1'b0;
    m_axis_tready = 1'b1;
    ntx = 0;
    for (int c = 0; c < 12 && !m_axis_tvalid; c++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      ntx++;
    end
    check("restart tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    check("restart tdata", {16'd0, m_axis_tdata}, 32'h4000);
    check("restart tuser", {31'd0, m_axis_tuser}, 32'd1);
`else
    // Throttled: two frames, same beats, extra idle cycles beyond the blanking.
    do_reset();
    i_mode = 2'd0;
    i_enable = 1'b1;
    m_axis_tready = 1'b1;
    ntx = 0;
    gaps = 0;
    for (int c = 0; c < 400 && ntx < 24; c++) begin
      if (m_axis_tvalid) begin
        check_beat("thr", ntx);
        ntx++;
      end else if (ntx > 0) begin
        gaps++;
      end
      if (ntx >= 13) i_enable = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
    end
    check("thr transfers", ntx, 32'd24);
    check("thr extra idle", {31'd0, gaps > 11}, 32'd1);
    repeat (6) @(negedge i_clk);
    check("thr frame_cnt", {16'd0, o_frame_cnt}, 32'd2);
    check("thr busy", {31'd0, o_busy}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
